// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
// Multiply/divide unit with HI/LO registers for a MIPS-style pipeline.
//
// A Start strobe is accepted only while the unit is idle. mult/multu/div/divu
// latch their operands and run for a fixed number of cycles, then write
// {HI,LO} at the edge that ends the busy window. mthi/mtlo write A straight
// into HI or LO at the accepting edge and never raise Busy.
//
// Ports
//   clk    in   1   clock, all state updates on the rising edge
//   reset  in   1   synchronous active-high reset
//   Start  in   1   one-cycle command strobe
//   MDOp   in   3   000 none, 001 mult, 010 multu, 011 div, 100 divu,
//                   101 mthi, 110 mtlo, 111 reserved
//   A      in  32   rs operand
//   B      in  32   rt operand
//   Busy   out  1   high while a mult/div is in flight
//   HI     out 32   HI register
//   LO     out 32   LO register
// -----------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [2:0]       r_op;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_signed_op;
    logic             w_is_div;
    logic [31:0]      w_a_mag;
    logic [31:0]      w_b_mag;
    logic [31:0]      w_opa;
    logic [31:0]      w_opb;
    logic [63:0]      w_prod;
    logic [31:0]      w_quot;
    logic [31:0]      w_rem;
    logic             w_res_neg;
    logic             w_rem_neg;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_res_we;

    assign Busy = (r_cnt != '0);
    assign HI   = r_hi;
    assign LO   = r_lo;

    // Signed ops run on magnitudes through the same unsigned multiplier and
    // divider, then fix the sign. |0x80000000| is still representable as an
    // unsigned 32-bit value, so 0x80000000 / -1 lands on 0x80000000 naturally.
    assign w_signed_op = (r_op == OP_MULT) || (r_op == OP_DIV);
    assign w_is_div    = (r_op == OP_DIV) || (r_op == OP_DIVU);
    assign w_a_mag     = r_a[31] ? (~r_a + 32'd1) : r_a;
    assign w_b_mag     = r_b[31] ? (~r_b + 32'd1) : r_b;
    assign w_opa       = w_signed_op ? w_a_mag : r_a;
    assign w_opb       = w_signed_op ? w_b_mag : r_b;

    assign w_prod      = {32'd0, w_opa} * {32'd0, w_opb};
    assign w_quot      = (w_opb == 32'd0) ? 32'd0 : (w_opa / w_opb);
    assign w_rem       = (w_opb == 32'd0) ? 32'd0 : (w_opa % w_opb);

    assign w_res_neg   = w_signed_op && (r_a[31] ^ r_b[31]);
    // Remainder follows the dividend's sign (truncating division).
    assign w_rem_neg   = (r_op == OP_DIV) && r_a[31];

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        w_res_we = 1'b0;
        if (w_is_div) begin
            // Divide by zero burns the full busy window but leaves HI/LO alone.
            w_res_we = (r_b != 32'd0);
            w_res_lo = w_res_neg ? (~w_quot + 32'd1) : w_quot;
            w_res_hi = w_rem_neg ? (~w_rem + 32'd1) : w_rem;
        end else if ((r_op == OP_MULT) || (r_op == OP_MULTU)) begin
            w_res_we = 1'b1;
            {w_res_hi, w_res_lo} = w_res_neg ? (~w_prod + 64'd1) : w_prod;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_op  <= OP_NONE;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            if ((r_cnt == CNT_W'(1)) && w_res_we) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else if (Start) begin
            case (MDOp)
                OP_MULT, OP_MULTU: begin
                    r_a   <= A;
                    r_b   <= B;
                    r_op  <= MDOp;
                    r_cnt <= CNT_W'(MULT_CYCLES);
                end
                OP_DIV, OP_DIVU: begin
                    r_a   <= A;
                    r_b   <= B;
                    r_op  <= MDOp;
                    r_cnt <= CNT_W'(DIV_CYCLES);
                end
                OP_MTHI: r_hi <= A;
                OP_MTLO: r_lo <= A;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    vec_t vecs[16];

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int exp_busy(input logic [2:0] op);
        case (op)
            3'd1, 3'd2: return 5;
            3'd3, 3'd4: return 10;
            default:    return 0;
        endcase
    endfunction

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] hi, inout logic [31:0] lo);
        longint p, q, r;
        logic [63:0] u;
        case (op)
            3'd1: begin
                p = longint'($signed(a)) * longint'($signed(b));
                hi = p[63:32]; lo = p[31:0];
            end
            3'd2: begin
                u = {32'd0, a} * {32'd0, b};
                hi = u[63:32]; lo = u[31:0];
            end
            3'd3: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                hi = r[31:0]; lo = q[31:0];
            end
            3'd4: if (b != 0) begin
                lo = a / b; hi = a % b;
            end
            3'd5: hi = a;
            3'd6: lo = a;
            default: ;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string name);
        int  n, cyc;
        bit  held;
        n = exp_busy(op); held = 1'b1; cyc = 0;
        @(negedge clk);
        Start = 1'b1; MDOp = op; A = a; B = b;
        @(posedge clk); #1;
        Start = 1'b0;
        while (Busy && cyc < 200) begin
            cyc++;
            if (HI !== m_hi || LO !== m_lo) held = 1'b0;
            // Garbage on the inputs (including new commands) must not matter.
            Start = 1'($urandom_range(0, 1)); MDOp = 3'($urandom);
            A = $urandom; B = $urandom;
            @(posedge clk); #1;
        end
        Start = 1'b0;
        chk({name, "_busy_cycles"}, 32'(cyc), 32'(n));
        if (n > 0) chk({name, "_held"}, 32'(held), 32'd1);
        chk({name, "_hi"}, HI, eh);
        chk({name, "_lo"}, LO, el);
        m_hi = eh; m_lo = el;
    endtask

    task automatic wait_idle(input int limit, output int cyc);
        cyc = 0;
        while (Busy && cyc < limit) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int cyc;
        logic [2:0]  op;
        logic [31:0] a, b, eh, el;

        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, "mult_neg1x2"};
        vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, "multu_max_x2"};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
        vecs[3]  = '{3'd4, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, "divu_by0"};
        vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
        vecs[5]  = '{3'd5, 32'hCAFEBABE, 32'd0,        32'hCAFEBABE, 32'h80000000, "mthi"};
        vecs[6]  = '{3'd6, 32'h12345678, 32'd0,        32'hCAFEBABE, 32'h12345678, "mtlo"};
        vecs[7]  = '{3'd0, 32'd5,        32'd5,        32'hCAFEBABE, 32'h12345678, "op_none"};
        vecs[8]  = '{3'd7, 32'd5,        32'd5,        32'hCAFEBABE, 32'h12345678, "op_rsvd"};
        vecs[9]  = '{3'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, "divu_100_7"};
        vecs[10] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7_m2"};
        vecs[11] = '{3'd1, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 32'h0000000C, "mult_m3_m4"};
        vecs[12] = '{3'd3, 32'd0,        32'd0,        32'h00000000, 32'h0000000C, "div_0_by0"};
        vecs[13] = '{3'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "multu_2p32"};
        vecs[14] = '{3'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, "div_m7_m2"};
        vecs[15] = '{3'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, "mult_minmax"};

        reset = 1'b1; Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;

        for (int i = 0; i < 16; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name);

        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) a = 32'h80000000;
            eh = m_hi; el = m_lo;
            model(op, a, b, eh, el);
            run_op(op, a, b, eh, el, "rand");
        end

        // mtlo strobed during busy cycle 3 of a div is dropped.
        @(negedge clk);
        Start = 1'b1; MDOp = 3'd3; A = 32'd100; B = 32'd9;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        Start = 1'b1; MDOp = 3'd6; A = 32'h1234;
        @(posedge clk); #1;
        Start = 1'b0;
        wait_idle(30, cyc);
        chk("div_mtlo_ignored_lo", LO, 32'd11);
        chk("div_mtlo_ignored_hi", HI, 32'd1);

        // Reset during busy cycle 4 of a mult aborts it.
        run_op(3'd5, 32'h55, 32'd0, 32'h55, 32'd11, "pre_abort_mthi");
        @(negedge clk);
        Start = 1'b1; MDOp = 3'd1; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        repeat (10) begin @(posedge clk); #1; end
        chk("abort_late_hi", HI, 32'd0);
        chk("abort_late_lo", LO, 32'd0);
        chk("abort_late_busy", 32'(Busy), 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        // Reset on the very edge where the result would land.
        run_op(3'd5, 32'h77, 32'd0, 32'h77, 32'd0, "pre_cnt1_mthi");
        @(negedge clk);
        Start = 1'b1; MDOp = 3'd1; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("cnt1_still_busy", 32'(Busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("cnt1_abort_hi", HI, 32'd0);
        chk("cnt1_abort_lo", LO, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        // Reset wins over a simultaneous mthi.
        run_op(3'd5, 32'h88, 32'd0, 32'h88, 32'd0, "pre_prio_mthi");
        @(negedge clk);
        Start = 1'b1; MDOp = 3'd5; A = 32'h99; reset = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0; reset = 1'b0;
        chk("reset_prio_hi", HI, 32'd0);

        // mthi then mult back-to-back.
        @(negedge clk);
        Start = 1'b1; MDOp = 3'd5; A = 32'hCAFEBABE;
        @(posedge clk); #1;
        chk("b2b_mthi_hi", HI, 32'hCAFEBABE);
        chk("b2b_mthi_busy", 32'(Busy), 32'd0);
        MDOp = 3'd1; A = 32'd3; B = 32'd5;
        @(posedge clk); #1;
        Start = 1'b0;
        chk("b2b_mult_hi_held", HI, 32'hCAFEBABE);
        wait_idle(50, cyc);
        chk("b2b_mult_busy_cycles", 32'(cyc), 32'd5);
        chk("b2b_mult_hi", HI, 32'd0);
        chk("b2b_mult_lo", LO, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
